serial_adder: RTL

Bit-serial add/subtract unit for area-constrained ALU configurations. It processes one bit per cycle through a single instance of the existing 1-bit `full_adder` cell. A registered carry closes the loop between bit steps. A start/done handshake fronts the unit, and it delivers a WIDTH-bit result, carry-out and signed overflow to the downstream writeback/flag logic.

---
 rtl/serial_adder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract unit built around one 1-bit full adder.
// Operands are loaded on an accepted start. One bit is resolved per clock,
// LSB first, and a registered carry links consecutive bit steps.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - request, accepted in IDLE or DONE
//   sub      - 0: a+b, 1: a-b (sampled with start)
//   a, b     - WIDTH-bit operands (sampled with start)
//   busy     - high while bit steps are in progress
//   done     - one-cycle pulse when result/cout/overflow are valid
//   result   - WIDTH-bit sum or difference
//   cout     - final carry out (subtract: 1 = no borrow)
//   overflow - signed overflow (carry into MSB xor carry out of MSB)

// One-bit full adder cell.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] count;
  // Holds the WIDTH-1 most recent sum bits; the final bit is merged in
  // directly when the result register is written.
  logic [WIDTH-2:0] partial;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_cat;

  full_adder u_fa (
    .x    (op_a[0]),
    .y    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB end; after the last step this is the answer.
  assign sum_cat = {fa_sum, partial};

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= {WIDTH{1'b0}};
      op_b     <= {WIDTH{1'b0}};
      carry    <= 1'b0;
      count    <= {CNT_W{1'b0}};
      partial  <= {(WIDTH-1){1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= {WIDTH{1'b0}};
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            op_a    <= a;
            // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
            op_b    <= sub ? ~b : b;
            carry   <= sub;
            count   <= {CNT_W{1'b0}};
            partial <= {(WIDTH-1){1'b0}};
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          op_a    <= {1'b0, op_a[WIDTH-1:1]};
          op_b    <= {1'b0, op_b[WIDTH-1:1]};
          carry   <= fa_cout;
          count   <= count + CNT_ONE;
          partial <= sum_cat[WIDTH-1:1];
          if (count == LAST_STEP) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= sum_cat;
            cout     <= fa_cout;
            // carry currently holds the carry into the MSB position.
            overflow <= carry ^ fa_cout;
          end else begin
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            op_a    <= a;
            op_b    <= sub ? ~b : b;
            carry   <= sub;
            count   <= {CNT_W{1'b0}};
            partial <= {(WIDTH-1){1'b0}};
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
